// File: rtl/timer_cap.sv
// timer_cap: parametrised general-purpose timer with a wrap/one-shot main counter,
// an independent periodic tick prescaler, preload, and an input-capture register
// with a valid/ack handshake and sticky overflow.
module timer_cap #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TICK_PERIOD = 1105919
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ena,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cap_in,
    input  logic             cap_ack,
    output logic [WIDTH-1:0] count,
    output logic             pulse_full,
    output logic             pulse_tick,
    output logic             done,
    output logic [WIDTH-1:0] cap_val,
    output logic             cap_valid,
    output logic             cap_ovf
);

    // Prescaler width is derived from the period; it is not meant to be overridden.
    localparam int unsigned       TICK_W  = $clog2(TICK_PERIOD + 1);
    localparam logic [TICK_W-1:0] TickMax = TICK_W'(TICK_PERIOD);
    localparam logic [WIDTH-1:0]  CntMax  = '1;

    logic [WIDTH-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_q, tick_d;
    logic              cap_d_q;
    logic [WIDTH-1:0]  cap_val_q, cap_val_d;
    logic              cap_valid_q, cap_valid_d;
    logic              cap_ovf_q, cap_ovf_d;
    logic              cap_edge;

    assign cap_edge = cap_in & ~cap_d_q;

    // Main counter next state: clr beats load beats ena.
    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        full_d  = 1'b0;
        if (clr) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (ena) begin
            if (count_q != CntMax) begin
                count_d = count_q + WIDTH'(1);
            end else if (!mode) begin
                count_d = '0;
                full_d  = 1'b1;
            end else if (!done_q) begin
                // One-shot expiry: hold at MAX and flag once.
                full_d = 1'b1;
                done_d = 1'b1;
            end
        end
    end

    // Tick prescaler next state; independent of count, load and mode.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        if (clr) begin
            tick_cnt_d = '0;
        end else if (ena) begin
            if (tick_cnt_q == TickMax) begin
                tick_cnt_d = '0;
                tick_d     = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    // Capture next state; samples the pre-update count and ignores ena.
    always_comb begin
        cap_val_d   = cap_val_q;
        cap_valid_d = cap_valid_q;
        cap_ovf_d   = cap_ovf_q;
        if (clr) begin
            cap_valid_d = 1'b0;
            cap_ovf_d   = 1'b0;
        end else if (cap_edge) begin
            if (!cap_valid_q || cap_ack) begin
                cap_val_d   = count_q;
                cap_valid_d = 1'b1;
            end else begin
                cap_ovf_d = 1'b1;
            end
        end else if (cap_ack) begin
            cap_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            tick_cnt_q  <= '0;
            tick_q      <= 1'b0;
            cap_d_q     <= 1'b0;
            cap_val_q   <= '0;
            cap_valid_q <= 1'b0;
            cap_ovf_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            done_q      <= done_d;
            full_q      <= full_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_q      <= tick_d;
            // Tracks cap_in even during clr so a held input cannot fake an edge.
            cap_d_q     <= cap_in;
            cap_val_q   <= cap_val_d;
            cap_valid_q <= cap_valid_d;
            cap_ovf_q   <= cap_ovf_d;
        end
    end

    assign count      = count_q;
    assign pulse_full = full_q;
    assign pulse_tick = tick_q;
    assign done       = done_q;
    assign cap_val    = cap_val_q;
    assign cap_valid  = cap_valid_q;
    assign cap_ovf    = cap_ovf_q;

endmodule
